// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing constants, coordinate/sync types and decode helpers.
// Imported by the sync generator and the pixel-draw blocks.
package vga_sync_gen_pkg;

  localparam int XY_W = 10;
  localparam int FC_W = 8;

  localparam int CLK_DIV_DEF   = 4;
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF =
    H_DISPLAY_DEF + H_FRONT_DEF +
    H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF =
    V_DISPLAY_DEF + V_FRONT_DEF +
    V_SYNC_DEF + V_BACK_DEF;

  typedef logic [XY_W-1:0] coord_t;
  typedef logic [FC_W-1:0] fcnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{
    hsync:    1'b1,
    vsync:    1'b1,
    video_on: 1'b1
  };

  function automatic logic in_span(
    input coord_t v,
    input int     lo,
    input int     hi
  );
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

  // Sync lines are active-low; video_on covers the visible rectangle.
  function automatic sync_t sync_decode(
    input coord_t x,
    input coord_t y,
    input int     h_disp,
    input int     hs_lo,
    input int     hs_hi,
    input int     v_disp,
    input int     vs_lo,
    input int     vs_hi
  );
    sync_t s;
    s.hsync    = ~in_span(x, hs_lo, hs_hi);
    s.vsync    = ~in_span(y, vs_lo, vs_hi);
    s.video_on = (int'(x) < h_disp) &&
                 (int'(y) < v_disp);
    return s;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Scan-position and sync bundle from the timing stage to draw blocks.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
import vga_sync_gen_pkg::*;

interface vga_sync_gen_if;

  logic   p_tick;
  coord_t x;
  coord_t y;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   frame_start;
`ifdef VGA_FRAME_CNT_EN
  fcnt_t  frame_cnt;
`endif

  modport master (
    output p_tick,
    output x,
    output y,
    output video_on,
    output hsync,
    output vsync,
`ifdef VGA_FRAME_CNT_EN
    output frame_cnt,
`endif
    output frame_start
  );

  modport slave (
    input p_tick,
    input x,
    input y,
    input video_on,
    input hsync,
    input vsync,
`ifdef VGA_FRAME_CNT_EN
    input frame_cnt,
`endif
    input frame_start
  );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Board-clock divider: registered one-clk pulse every CLK_DIV clocks.
// First pulse lands CLK_DIV clocks after reset is released.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick_o
);

  localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_q;
  logic [W-1:0] div_d;
  logic         tick_q;
  logic         tick_d;
  logic         at_last;

  always_comb begin
    at_last = (div_q == LAST);
    div_d   = at_last ? '0 : div_q + 1'b1;
    tick_d  = at_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign p_tick_o = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA scan timing: pixel counters, syncs, frame strobe.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame counter output.
import vga_sync_gen_pkg::*;

module vga_sync_gen #(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic          clk,
  input  logic          reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO = H_DISPLAY + H_FRONT;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_DISPLAY + V_FRONT;
  localparam int VS_HI = VS_LO + V_SYNC - 1;

  localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);

  logic   p_tick;
  logic   x_wrap;
  logic   y_wrap;
  coord_t x_q;
  coord_t x_d;
  coord_t y_q;
  coord_t y_d;
  sync_t  sync_q;
  sync_t  sync_d;
  logic   fs_q;
  logic   fs_d;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .p_tick_o (p_tick)
  );

  always_comb begin
    x_wrap = (x_q == X_LAST);
    y_wrap = (y_q == Y_LAST);
    x_d    = x_q;
    y_d    = y_q;
    if (p_tick) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = y_wrap ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    fs_d = p_tick & x_wrap & y_wrap;
  end

  // Decode from next-state counters so syncs move with x/y.
  always_comb begin
    sync_d = sync_decode(
      x_d, y_d,
      H_DISPLAY, HS_LO, HS_HI,
      V_DISPLAY, VS_LO, VS_HI
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      sync_q <= SYNC_IDLE;
      fs_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      sync_q <= sync_d;
      fs_q   <= fs_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  fcnt_t fc_q;
  fcnt_t fc_d;

  always_comb begin
    fc_d = fc_q + {{(FC_W-1){1'b0}}, fs_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_d;
    end
  end

  assign vga.frame_cnt = fc_q;
`endif

  assign vga.p_tick      = p_tick;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.hsync       = sync_q.hsync;
  assign vga.vsync       = sync_q.vsync;
  assign vga.video_on    = sync_q.video_on;
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size timing for the line, a shrunken
// instance (8x8 scan, CLK_DIV=2) for vertical and frame events.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if vif_a ();
  vga_sync_gen_if vif_b ();

  vga_sync_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (vif_a)
  );

  // Small timing: hsync low x=5..6, vsync low y=5..6, totals 8.
  vga_sync_gen #(
    .CLK_DIV   (2),
    .H_DISPLAY (4),
    .H_FRONT   (1),
    .H_SYNC    (2),
    .H_BACK    (1),
    .V_DISPLAY (4),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (vif_b)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_a(
    input int    tx,
    input int    ty,
    input int    lim,
    input string tag
  );
    int n = 0;
    while (!(vif_a.x == tx && vif_a.y == ty) && n < lim) begin
      step(1);
      n++;
    end
    chk({tag, "_reach"},
        32'(vif_a.x == tx && vif_a.y == ty), 32'd1);
  endtask

  task automatic wait_b(
    input int    tx,
    input int    ty,
    input int    lim,
    input string tag
  );
    int n = 0;
    while (!(vif_b.x == tx && vif_b.y == ty) && n < lim) begin
      step(1);
      n++;
    end
    chk({tag, "_reach"},
        32'(vif_b.x == tx && vif_b.y == ty), 32'd1);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(2);

    chk("rst_x",        32'(vif_a.x), 32'd0);
    chk("rst_y",        32'(vif_a.y), 32'd0);
    chk("rst_hsync",    32'(vif_a.hsync), 32'd1);
    chk("rst_vsync",    32'(vif_a.vsync), 32'd1);
    chk("rst_video_on", 32'(vif_a.video_on), 32'd1);
    chk("rst_p_tick",   32'(vif_a.p_tick), 32'd0);
    chk("rst_fstart",   32'(vif_a.frame_start), 32'd0);
`ifdef VGA_FRAME_CNT_EN
    chk("rst_fcnt",     32'(vif_a.frame_cnt), 32'd0);
`endif

    rst_a = 1'b0;
    step(3);
    chk("tick_clk3",    32'(vif_a.p_tick), 32'd0);
    chk("x_clk3",       32'(vif_a.x), 32'd0);
    step(1);
    chk("tick_clk4",    32'(vif_a.p_tick), 32'd1);
    chk("x_clk4",       32'(vif_a.x), 32'd0);
    step(1);
    chk("x_clk5",       32'(vif_a.x), 32'd1);
    chk("tick_clk5",    32'(vif_a.p_tick), 32'd0);
    step(3);
    chk("tick_clk8",    32'(vif_a.p_tick), 32'd1);
    step(1);
    chk("x_clk9",       32'(vif_a.x), 32'd2);

    wait_a(639, 0, 3000, "a639");
    chk("von_x639",     32'(vif_a.video_on), 32'd1);
    step(4);
    chk("x_640",        32'(vif_a.x), 32'd640);
    chk("von_x640",     32'(vif_a.video_on), 32'd0);

    wait_a(655, 0, 100, "a655");
    chk("hs_x655",      32'(vif_a.hsync), 32'd1);
    step(3);
    chk("x_hold655",    32'(vif_a.x), 32'd655);
    step(1);
    chk("x_656",        32'(vif_a.x), 32'd656);
    chk("hs_x656",      32'(vif_a.hsync), 32'd0);
    wait_a(751, 0, 500, "a751");
    chk("hs_x751",      32'(vif_a.hsync), 32'd0);
    step(4);
    chk("x_752",        32'(vif_a.x), 32'd752);
    chk("hs_x752",      32'(vif_a.hsync), 32'd1);

    wait_a(799, 0, 300, "a799");
    step(4);
    chk("a_wrap_x",     32'(vif_a.x), 32'd0);
    chk("a_wrap_y",     32'(vif_a.y), 32'd1);
    chk("a_fs_line",    32'(vif_a.frame_start), 32'd0);

    wait_a(700, 1, 3000, "a700");
    chk("hs_x700",      32'(vif_a.hsync), 32'd0);
    rst_a = 1'b1;
    step(1);
    chk("a_mid_x",      32'(vif_a.x), 32'd0);
    chk("a_mid_y",      32'(vif_a.y), 32'd0);
    chk("a_mid_hs",     32'(vif_a.hsync), 32'd1);
    chk("a_mid_tick",   32'(vif_a.p_tick), 32'd0);
    rst_a = 1'b0;

    // Small instance restarted so frame counting starts clean.
    rst_b = 1'b1;
    step(1);
    rst_b = 1'b0;
    wait_b(7, 1, 200, "b71");
    step(2);
    chk("b_line_x",     32'(vif_b.x), 32'd0);
    chk("b_line_y",     32'(vif_b.y), 32'd2);
    wait_b(0, 4, 200, "b04");
    chk("b_von_y4",     32'(vif_b.video_on), 32'd0);
    wait_b(7, 4, 200, "b74");
    chk("b_vs_y4",      32'(vif_b.vsync), 32'd1);
    step(2);
    chk("b_y5",         32'(vif_b.y), 32'd5);
    chk("b_vs_y5",      32'(vif_b.vsync), 32'd0);
    wait_b(0, 7, 200, "b07");
    chk("b_vs_y7",      32'(vif_b.vsync), 32'd1);
    wait_b(7, 7, 200, "b77");
    chk("b_fs_pre",     32'(vif_b.frame_start), 32'd0);
    step(2);
    chk("b_frame_x",    32'(vif_b.x), 32'd0);
    chk("b_frame_y",    32'(vif_b.y), 32'd0);
    chk("b_fs_hi",      32'(vif_b.frame_start), 32'd1);
`ifdef VGA_FRAME_CNT_EN
    chk("b_fcnt1",      32'(vif_b.frame_cnt), 32'd1);
`endif
    step(1);
    chk("b_fs_lo",      32'(vif_b.frame_start), 32'd0);

`ifdef VGA_FRAME_CNT_EN
    begin
      int n = 0;
      while (vif_b.frame_cnt != 8'd255 && n < 40000) begin
        step(1);
        n++;
      end
      chk("b_fcnt255",  32'(vif_b.frame_cnt), 32'd255);
    end
    wait_b(7, 7, 200, "b77w");
    step(2);
    chk("b_fcnt_wrap",  32'(vif_b.frame_cnt), 32'd0);
    chk("b_fs_wrap",    32'(vif_b.frame_start), 32'd1);
`endif

    wait_b(6, 6, 300, "b66");
    chk("b_hs_66",      32'(vif_b.hsync), 32'd0);
    chk("b_vs_66",      32'(vif_b.vsync), 32'd0);
    rst_b = 1'b1;
    step(1);
    chk("b_mid_x",      32'(vif_b.x), 32'd0);
    chk("b_mid_y",      32'(vif_b.y), 32'd0);
    chk("b_mid_hs",     32'(vif_b.hsync), 32'd1);
    chk("b_mid_vs",     32'(vif_b.vsync), 32'd1);
    chk("b_mid_von",    32'(vif_b.video_on), 32'd1);
    chk("b_mid_fs",     32'(vif_b.frame_start), 32'd0);
    rst_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
